tc_array: RTL and testbench
===========================

Name: tc_array

Overview:
- Parametrised multi-channel timer/counter peripheral. It is the successor to the single-channel TC, and one instance replaces the separate TC0/TC1 instances behind the Bridge.
- Provides NUM_CH independent down-counters of WIDTH bits.
- Each channel has a power-of-two prescaler, one-shot and auto-reload modes, a sticky pending flag and a mask bit.
- A global write-1-to-clear status register serves all channels; IRQ outputs go per channel into the CPU HWInt vector.

Parameters:
NUM_CH, 2, number of timer channels (1..8)
WIDTH, 32, counter/preset width in bits (8..32)
AW, 6, width of word-offset address input; must satisfy 2^AW > NUM_CH*4

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
WE  input  1  write enable for the addressed register
Addr  input  AW  word offset within the block (byte address [AW+1:2], decoded by Bridge)
Din  input  32  write data
Dout  output  32  read data (combinational on Addr)
IRQ  output  NUM_CH  per-channel interrupt = pending[c] & IM[c]
IRQ_any  output  1  OR of IRQ

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. On reset all CTRL/PRESET/COUNT/prescaler/pending clear to 0, every channel FSM goes to IDLE, and IRQ, IRQ_any and Dout (for any in-range address) are 0.
- Address map (word offsets):
  - channel c: 4c = CTRL, 4c+1 = PRESET, 4c+2 = COUNT (read-only), 4c+3 = reserved (reads 0).
  - 4*NUM_CH = STATUS: bit c = pending[c], write 1 to clear.
  - Other offsets read 0; writes to them are ignored.
- CTRL fields, bits[7:0] only; bits[31:8] read 0.
  - [0] EN.
  - [2:1] MODE: 00 one-shot, 01 auto-reload; 10 and 11 behave as 00.
  - [3] IM (interrupt mask enable).
  - [7:4] PS: a tick occurs every 2^PS cycles.
- PRESET/COUNT: low WIDTH bits; upper bits read 0 and are ignored on write.
- Per-channel FSM, advancing one step per clk edge:
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET, pre <= 0, go to CNT.
  - CNT: pre increments each cycle. On a cycle where pre == 2^PS-1 (a tick), pre <= 0 and:
    - if COUNT <= 1, COUNT <= 0 and go to INT;
    - otherwise COUNT <= COUNT-1.
  - INT: pending <= 1, go to IDLE. In one-shot mode, EN is also cleared in this cycle.
- Auto-reload: EN stays 1, so IDLE→LOAD repeats and the period is PRESET*2^PS+3 cycles.
- CTRL write (any state):
  - takes effect at the same edge and clears that channel's pending bit;
  - if the new EN=0, next state is IDLE and COUNT is held;
  - if the new EN=1 while in CNT/LOAD/INT, next state is IDLE, so the channel restarts via LOAD.
- PRESET write does not disturb a running count; it is used at the next LOAD.
- COUNT writes are ignored.
- Simultaneous events:
  - INT-state set and STATUS W1C of the same bit in one cycle: set wins.
  - INT-state set and a CTRL write of the same channel in one cycle: the CTRL write wins (pending stays 0).
- PRESET = 0 is treated as 1: INT is reached after one tick.
- IRQ is level; it stays high until pending is cleared or IM is cleared.
- Reset asserted mid-count overrides everything at that edge.

Test Plan:
- Reset then read all offsets: Dout = 0 everywhere; IRQ = 0; IRQ_any = 0.
- One-shot: ch0 PRESET=3, then CTRL=0x9 written at edge E0.
  - Required: COUNT=3 after E0+2, 2 after E0+3, 1 after E0+4, 0 after E0+5.
  - IRQ[0]=1 after E0+6; CTRL reads 0x8.
  - Writing STATUS=0x1 drops IRQ[0] at the next edge.
- Auto-reload: ch1 PRESET=2, CTRL=0xB at E0.
  - Required: pending[1] set after E0+5 and again after E0+10 (period 5); COUNT reloads to 2 after E0+7.
  - With IM=0 (CTRL=0x3), IRQ[1] stays 0 while STATUS bit1 = 1.
- Prescaler: ch0 PRESET=2, CTRL=0x29 (PS=2) at E0.
  - Required: COUNT=2 after E0+2, 1 after E0+6, 0 after E0+10; IRQ[0] after E0+11.
- Collisions:
  - STATUS W1C on the same edge ch0 enters INT→IDLE: pending[0] = 1 afterwards.
  - CTRL=0x0 written mid-count (COUNT=5): COUNT holds at 5, no IRQ.
  - Reset asserted mid-count: all registers 0 next cycle.
- NUM_CH=4, WIDTH=8: PRESET write 0x1FF reads back 0xFF. Channels 0-3 run concurrently with distinct presets, and IRQ_any = OR of IRQ.

Source files
------------

// File: rtl/tc_array.sv
// tc_array: NUM_CH independent prescaled down-counters sharing one register
// window. Each channel runs IDLE -> LOAD -> CNT -> INT, sets a sticky pending
// bit at INT, and raises IRQ when that bit and its mask enable are both set.
module tc_array #(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 32,
    parameter int AW     = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              WE,
    input  logic [AW-1:0]     Addr,
    input  logic [31:0]       Din,
    output logic [31:0]       Dout,
    output logic [NUM_CH-1:0] IRQ,
    output logic              IRQ_any
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

    // Prescaler counter must reach 2^15-1 for the largest PS value.
    localparam int PRE_W = 15;

    state_t             r_state     [NUM_CH];
    state_t             w_state_nxt [NUM_CH];
    logic [7:0]         r_ctrl      [NUM_CH];
    logic [WIDTH-1:0]   r_preset    [NUM_CH];
    logic [WIDTH-1:0]   r_count     [NUM_CH];
    logic [PRE_W-1:0]   r_pre       [NUM_CH];
    logic [NUM_CH-1:0]  r_pending;

    logic [PRE_W-1:0]   w_pre_max   [NUM_CH];
    logic [NUM_CH-1:0]  w_sel;
    logic [NUM_CH-1:0]  w_ctrl_we;
    logic [NUM_CH-1:0]  w_preset_we;
    logic [NUM_CH-1:0]  w_tick;
    logic [NUM_CH-1:0]  w_last;
    logic [NUM_CH-1:0]  w_oneshot;
    logic [NUM_CH-1:0]  w_im;
    logic               w_stat_sel;
    logic               w_stat_we;

    // Address decode: which channel register or the status word is addressed.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_sel       = '0;
        w_ctrl_we   = '0;
        w_preset_we = '0;
        w_stat_sel  = (Addr == AW'(NUM_CH * 4));
        w_stat_we   = WE && w_stat_sel;
        for (int c = 0; c < NUM_CH; c++) begin
            w_sel[c]       = (Addr[AW-1:2] == (AW-2)'(c));
            w_ctrl_we[c]   = WE && w_sel[c] && (Addr[1:0] == 2'd0);
            w_preset_we[c] = WE && w_sel[c] && (Addr[1:0] == 2'd1);
        end
    end

    // Per-channel tick, terminal-count and mode qualifiers.
    always_comb begin
        w_tick    = '0;
        w_last    = '0;
        w_oneshot = '0;
        w_im      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_pre_max[c] = PRE_W'((16'd1 << r_ctrl[c][7:4]) - 16'd1);
            w_tick[c]    = (r_state[c] == S_CNT) && (r_pre[c] == w_pre_max[c]);
            // A count of 0 (PRESET 0) finishes on the first tick, same as 1.
            w_last[c]    = (r_count[c] <= WIDTH'(1));
            // Only MODE 01 reloads; 00, 10 and 11 all stop after one period.
            w_oneshot[c] = (r_ctrl[c][2:1] != 2'b01);
            w_im[c]      = r_ctrl[c][3];
        end
    end

    // Next-state logic; any CTRL write parks the channel in IDLE.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_state_nxt[c] = r_state[c];
            case (r_state[c])
                S_IDLE:  if (r_ctrl[c][0]) w_state_nxt[c] = S_LOAD;
                S_LOAD:  w_state_nxt[c] = S_CNT;
                S_CNT:   if (w_tick[c] && w_last[c]) w_state_nxt[c] = S_INT;
                S_INT:   w_state_nxt[c] = S_IDLE;
                default: w_state_nxt[c] = S_IDLE;
            endcase
            if (w_ctrl_we[c]) w_state_nxt[c] = S_IDLE;
        end
    end

    // State register for all channel FSMs.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (reset) begin
                // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
                r_state[c] <= S_IDLE;
            end else begin
                r_state[c] <= w_state_nxt[c];
            end
        end
    end

    // Channel datapath: control, preset, counter, prescaler and pending bits.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (reset) begin
                r_ctrl[c]    <= '0;
                r_preset[c]  <= '0;
                r_count[c]   <= '0;
                r_pre[c]     <= '0;
                r_pending[c] <= 1'b0;
            end else begin
                if (w_preset_we[c]) r_preset[c] <= Din[WIDTH-1:0];

                if (w_ctrl_we[c]) begin
                    // The write supersedes whatever the FSM would do this edge;
                    // COUNT is held and pending is cleared.
                    r_ctrl[c]    <= Din[7:0];
                    r_pending[c] <= 1'b0;
                end else begin
                    case (r_state[c])
                        S_LOAD: begin
                            r_count[c] <= r_preset[c];
                            r_pre[c]   <= '0;
                        end
                        S_CNT: begin
                            if (w_tick[c]) begin
                                r_pre[c]   <= '0;
                                r_count[c] <= w_last[c] ? '0 : r_count[c] - WIDTH'(1);
                            end else begin
                                r_pre[c] <= r_pre[c] + PRE_W'(1);
                            end
                        end
                        default: ;
                    endcase

                    // Setting pending at INT beats a same-cycle STATUS clear.
                    if (r_state[c] == S_INT) begin
                        r_pending[c] <= 1'b1;
                        if (w_oneshot[c]) r_ctrl[c][0] <= 1'b0;
                    end else if (w_stat_we && Din[c]) begin
                        r_pending[c] <= 1'b0;
                    end
                end
            end
        end
    end

    // Interrupt outputs and combinational read mux.
    always_comb begin
        IRQ     = r_pending & w_im;
        IRQ_any = |IRQ;
        Dout    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_sel[c]) begin
                case (Addr[1:0])
                    2'd0:    Dout = {24'd0, r_ctrl[c]};
                    2'd1:    Dout = 32'(r_preset[c]);
                    2'd2:    Dout = 32'(r_count[c]);
                    default: Dout = '0;
                endcase
            end
        end
        if (w_stat_sel) Dout = 32'(r_pending);
    end

endmodule

// File: tb/tb_tc_array.sv
// Self-checking bench for tc_array (4 channels, 8-bit counters). A timeline
// model per channel predicts every register and IRQ each cycle; directed
// sequences pin both the DUT and the model to hand-computed values.
module tb_tc_array;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;
    localparam int AW     = 6;
    localparam int STAT   = 4 * NUM_CH;

    logic              clk = 1'b0;
    logic              reset;
    logic              WE;
    logic [AW-1:0]     Addr;
    logic [31:0]       Din;
    logic [31:0]       Dout;
    logic [NUM_CH-1:0] IRQ;
    logic              IRQ_any;

    int n_chk = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    tc_array #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .AW(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .WE      (WE),
        .Addr    (Addr),
        .Din     (Din),
        .Dout    (Dout),
        .IRQ     (IRQ),
        .IRQ_any (IRQ_any)
    );

    always #5 clk = ~clk;

    // Model: a running channel is described by its age (edges since the
    // IDLE->LOAD edge). Age 1 loads; ticks fall every T edges afterwards;
    // the pending bit is set at age P*T+2. Age -1 means idle.
    logic [7:0] m_ctrl [NUM_CH];
    int         m_preset [NUM_CH];
    int         m_count  [NUM_CH];
    bit         m_pend   [NUM_CH];
    int         m_age    [NUM_CH];
    int         m_p      [NUM_CH];
    int         m_t      [NUM_CH];

    always @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (reset) begin
                m_ctrl[c] = '0; m_preset[c] = 0; m_count[c] = 0;
                m_pend[c] = 1'b0; m_age[c] = -1; m_p[c] = 1; m_t[c] = 1;
            end else begin
                if (WE && int'(Addr) == STAT && Din[c]) m_pend[c] = 1'b0;
                if (WE && int'(Addr) == 4 * c) begin
                    m_ctrl[c] = Din[7:0];
                    m_pend[c] = 1'b0;
                    m_age[c]  = -1;
                end else if (m_age[c] < 0) begin
                    if (m_ctrl[c][0]) m_age[c] = 0;
                end else begin
                    m_age[c]++;
                    if (m_age[c] == 1) begin
                        m_count[c] = m_preset[c];
                        m_p[c]     = (m_preset[c] == 0) ? 1 : m_preset[c];
                        m_t[c]     = 1 << m_ctrl[c][7:4];
                    end else if (m_age[c] == m_p[c] * m_t[c] + 2) begin
                        m_pend[c] = 1'b1;
                        if (m_ctrl[c][2:1] != 2'b01) m_ctrl[c][0] = 1'b0;
                        m_age[c] = -1;
                    end else if ((m_age[c] - 1) % m_t[c] == 0) begin
                        m_count[c] = m_p[c] - (m_age[c] - 1) / m_t[c];
                    end
                end
                if (WE && int'(Addr) == 4 * c + 1) m_preset[c] = int'(Din[WIDTH-1:0]);
            end
        end
    end

    function automatic logic [31:0] model_read(input int a);
        logic [31:0] v;
        v = '0;
        if (a < STAT) begin
            case (a % 4)
                0: v = 32'(m_ctrl[a / 4]);
                1: v = 32'(m_preset[a / 4]);
                2: v = 32'(m_count[a / 4]);
                default: v = '0;
            endcase
        end else if (a == STAT) begin
            for (int c = 0; c < NUM_CH; c++) v[c] = m_pend[c];
        end
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] model_irq();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_pend[c] & m_ctrl[c][3];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, the DUT outputs must match the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_dout", Dout, model_read(int'(Addr)));
            check("cmp_irq", 32'(IRQ), 32'(model_irq()));
            check("cmp_irq_any", 32'(IRQ_any), 32'(|model_irq()));
        end
    end

    // One clock edge with the given bus inputs applied.
    task automatic cyc(input logic we, input int a, input logic [31:0] d);
        WE = we; Addr = a[AW-1:0]; Din = d;
        @(posedge clk); #2;
        WE = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            WE = 1'b0;
            @(posedge clk); #2;
        end
    endtask

    // Read an offset without consuming an edge; pins DUT and model alike.
    task automatic peek(input int a, input logic [31:0] exp, input string name);
        WE = 1'b0; Addr = a[AW-1:0];
        #1;
        check(name, Dout, exp);
        check({name, "_model"}, model_read(a), exp);
    endtask

    task automatic all_zero(input string name);
        for (int a = 0; a <= STAT + 1; a++) begin
            peek(a, 32'd0, name);
            idle(1);
        end
        check({name, "_irq"}, 32'(IRQ), 32'd0);
        check({name, "_irq_any"}, 32'(IRQ_any), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int          a;
        int          r;

        reset = 1'b1; WE = 1'b0; Addr = '0; Din = '0;
        @(posedge clk); #2;
        cmp_en = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;

        // Reset state
        all_zero("rst_rd");

        // One-shot, ch0 PRESET=3
        cyc(1, 1, 3);
        cyc(1, 0, 32'h9);
        idle(2); peek(2, 3, "os_cnt_e2");
        idle(1); peek(2, 2, "os_cnt_e3");
        idle(1); peek(2, 1, "os_cnt_e4");
        idle(1); peek(2, 0, "os_cnt_e5");
        idle(1);
        check("os_irq0_e6", 32'(IRQ[0]), 32'd1);
        peek(0, 32'h8, "os_ctrl");
        peek(STAT, 32'h1, "os_status");
        cyc(1, STAT, 32'h1);
        check("os_w1c_irq0", 32'(IRQ[0]), 32'd0);

        // Auto-reload, ch1 PRESET=2
        cyc(1, 5, 2);
        cyc(1, 4, 32'hB);
        idle(5);
        check("ar_irq1_e5", 32'(IRQ[1]), 32'd1);
        peek(STAT, 32'h2, "ar_pend_e5");
        cyc(1, STAT, 32'h2);
        peek(STAT, 32'h0, "ar_clr_e6");
        idle(1); peek(6, 2, "ar_reload_e7");
        idle(3); peek(STAT, 32'h2, "ar_pend_e10");
        cyc(1, 4, 32'h3);
        idle(5);
        peek(STAT, 32'h2, "ar_im0_status");
        check("ar_im0_irq1", 32'(IRQ[1]), 32'd0);
        cyc(1, 4, 32'h0);

        // Prescaler, ch0 PRESET=2 PS=2
        cyc(1, 1, 2);
        cyc(1, 0, 32'h29);
        idle(2);  peek(2, 2, "ps_cnt_e2");
        idle(4);  peek(2, 1, "ps_cnt_e6");
        idle(4);  peek(2, 0, "ps_cnt_e10");
        check("ps_irq0_not_yet", 32'(IRQ[0]), 32'd0);
        idle(1);
        check("ps_irq0_e11", 32'(IRQ[0]), 32'd1);
        check("ps_irq_any_e11", 32'(IRQ_any), 32'd1);
        cyc(1, 0, 32'h0);

        // STATUS clear on the same edge as the INT set: set wins
        cyc(1, 1, 1);
        cyc(1, 0, 32'h9);
        idle(3);
        cyc(1, STAT, 32'h1);
        peek(STAT, 32'h1, "col_w1c_set");

        // CTRL write on the INT edge: the write wins
        cyc(1, 0, 32'h9);
        idle(3);
        cyc(1, 0, 32'h9);
        peek(STAT, 32'h0, "col_ctrl_wins");
        check("col_ctrl_irq0", 32'(IRQ[0]), 32'd0);
        cyc(1, 0, 32'h0);

        // Disable mid-count holds COUNT
        cyc(1, 1, 8);
        cyc(1, 0, 32'h9);
        idle(5); peek(2, 5, "col_mid_cnt5");
        cyc(1, 0, 32'h0);
        idle(5); peek(2, 5, "col_hold_cnt5");
        peek(STAT, 32'h0, "col_hold_status");
        check("col_hold_irq", 32'(IRQ), 32'd0);

        // PRESET 0 behaves as 1
        cyc(1, 12, 32'h9);
        idle(3); peek(STAT, 32'h0, "p0_not_yet");
        idle(1); peek(STAT, 32'h8, "p0_pend");
        check("p0_irq3", 32'(IRQ[3]), 32'd1);
        cyc(1, STAT, 32'h8);

        // Width truncation, read-only COUNT, reserved word, out-of-range
        cyc(1, 13, 32'h1FF);  peek(13, 32'hFF, "preset_trunc");
        cyc(1, 14, 32'h55);   peek(14, 32'h0, "count_ro");
        cyc(1, 15, 32'hFFFF); peek(15, 32'h0, "reserved_rd");
        cyc(1, 40, 32'hFF);   peek(40, 32'h0, "oor_rd");

        // Reset in the middle of a count
        cyc(1, 9, 200);
        cyc(1, 8, 32'h9);
        idle(5);
        reset = 1'b1; idle(1); reset = 1'b0;
        all_zero("rst_mid");

        // Four channels running concurrently with distinct presets
        cyc(1, 1, 3); cyc(1, 5, 5); cyc(1, 9, 7); cyc(1, 13, 4);
        for (int c = 0; c < NUM_CH; c++) cyc(1, 4 * c, 32'hB);
        for (int i = 0; i < 80; i++) cyc(0, $urandom_range(0, STAT), 0);

        // Randomized traffic
        for (int i = 0; i < 6000; i++) begin
            r = $urandom_range(0, 199);
            if (r < 1) begin
                reset = 1'b1; cyc(0, 0, 0); reset = 1'b0;
            end else if (r < 40) begin
                a = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, STAT);
                d = $urandom();
                if (a < STAT && a % 4 == 0) begin
                    d[7:4] = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 4));
                    d[0]   = ($urandom_range(0, 3) != 0);
                end else if (a < STAT && a % 4 == 1) begin
                    if ($urandom_range(0, 3) != 0) d = 32'($urandom_range(0, 6));
                end
                cyc(1, a, d);
            end else begin
                cyc(0, $urandom_range(0, STAT + 2), $urandom());
            end
        end

        idle(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
